// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU and an external requester (define DMEM_ARB_CPU_PRIO_EN for strict CPU priority)
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_gnt,
    output logic          ext_rvalid,
    output logic [DW-1:0] ext_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, OWN_CPU, OWN_EXT} state_t;
    state_t state, state_nx;
    logic   gc, ge, rd_pend, rd_ext;
`ifdef DMEM_ARB_CPU_PRIO_EN
    // strict CPU priority; state only remembers the last owner for busy
    always_comb begin
        gc       = cpu_req;
        ge       = ext_req & ~cpu_req;
        state_nx = gc ? OWN_CPU : ge ? OWN_EXT : IDLE;
    end
    // owner register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end
`else
    localparam logic [2:0] MAXC = 3'(MAX_BURST);
    logic [2:0] cnt, cnt_nx;
    logic       own_ext, mine, other;
    assign own_ext = state == OWN_EXT;
    assign mine    = own_ext ? ext_req : cpu_req;
    assign other   = own_ext ? cpu_req : ext_req;
    // burst-limited round robin: owner keeps the port until it idles or hits the burst cap while contended
    always_comb begin
        gc       = 1'b0;
        ge       = 1'b0;
        state_nx = IDLE;
        cnt_nx   = 3'd0;
        if (state == IDLE) begin
            gc = cpu_req;
            ge = ext_req & ~cpu_req;
        end else if (mine && !(other && cnt >= MAXC)) begin
            gc = ~own_ext;
            ge = own_ext;
        end else if (other) begin
            gc = own_ext;
            ge = ~own_ext;
        end
        state_nx = gc ? OWN_CPU : ge ? OWN_EXT : IDLE;
        cnt_nx   = !(gc || ge) ? 3'd0 : (state_nx != state) ? 3'd1 : (cnt >= MAXC) ? MAXC : cnt + 3'd1;
    end
    // owner and burst counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
`endif
    // one-entry tag: remembers who issued the read whose data arrives next cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_pend <= 1'b0;
            rd_ext  <= 1'b0;
        end else begin
            rd_pend <= (gc & ~cpu_we) | (ge & ~ext_we);
            rd_ext  <= ge;
        end
    end
    assign cpu_gnt    = rst & gc;
    assign ext_gnt    = rst & ge;
    assign mem_we     = rst & ((gc & cpu_we) | (ge & ext_we));
    assign mem_addr   = !rst ? '0 : gc ? cpu_addr : ge ? ext_addr : '0;
    assign mem_wdata  = !rst ? '0 : gc ? cpu_wdata : ge ? ext_wdata : '0;
    assign cpu_rvalid = rst & rd_pend & ~rd_ext;
    assign ext_rvalid = rst & rd_pend & rd_ext;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign ext_rdata  = ext_rvalid ? mem_rdata : '0;
    assign busy       = rst & ((state != IDLE) | rd_pend);
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a cycle-level arbitration model
module tb_dmem_arbiter;
    localparam int MB = 4;
    logic        clk = 1'b0, rst = 1'b0;
    logic        cpu_req = 0, cpu_we = 0, ext_req = 0, ext_we = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, ext_addr = 0, ext_wdata = 0, mem_rdata = 0;
    logic        cpu_gnt, cpu_rvalid, ext_gnt, ext_rvalid, mem_we, busy;
    logic [31:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata;
    typedef struct {logic ext; logic [31:0] data;} rd_t;
    rd_t         q[$];
    int          m_state = 0, m_cnt = 0, nvec = 0, nerr = 0;
    logic [31:0] mem_next = 0;
    logic        og_c, og_e;
    logic [15:0] pat;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    function automatic logic [31:0] memval(input logic [31:0] a);
        return (a == 32'h1001_0010) ? 32'hCAFE_F00D : {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic er, input logic ew, input logic [31:0] ea, input logic [31:0] ed);
        int g;
        logic mine, other, rvc, rve, busy_e;
        logic [31:0] rd;
        @(posedge clk);
        #1;
        rst = r; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        ext_req = er; ext_we = ew; ext_addr = ea; ext_wdata = ed; mem_rdata = mem_next;
        g = 0;
        if (r) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
            g = cr ? 1 : er ? 2 : 0;
`else
            if (m_state == 0) g = cr ? 1 : er ? 2 : 0;
            else begin
                mine  = (m_state == 1) ? cr : er;
                other = (m_state == 1) ? er : cr;
                if (mine && !(other && m_cnt >= MB)) g = m_state;
                else if (other) g = 3 - m_state;
            end
`endif
        end
        rvc    = r && q.size() > 0 && !q[0].ext;
        rve    = r && q.size() > 0 && q[0].ext;
        rd     = (q.size() > 0) ? q[0].data : 32'h0;
        busy_e = r && (m_state != 0 || q.size() > 0);
        @(negedge clk);
        chk("cpu_gnt", 64'(cpu_gnt), 64'(g == 1));
        chk("ext_gnt", 64'(ext_gnt), 64'(g == 2));
        chk("mem_we", 64'(mem_we), 64'((g == 1 && cw) || (g == 2 && ew)));
        chk("mem_addr", 64'(mem_addr), 64'(g == 1 ? ca : g == 2 ? ea : 32'h0));
        chk("mem_wdata", 64'(mem_wdata), 64'(g == 1 ? cd : g == 2 ? ed : 32'h0));
        chk("cpu_rvalid", 64'(cpu_rvalid), 64'(rvc));
        chk("cpu_rdata", 64'(cpu_rdata), 64'(rvc ? rd : 32'h0));
        chk("ext_rvalid", 64'(ext_rvalid), 64'(rve));
        chk("ext_rdata", 64'(ext_rdata), 64'(rve ? rd : 32'h0));
        chk("busy", 64'(busy), 64'(busy_e));
        og_c = cpu_gnt;
        og_e = ext_gnt;
        if (q.size() > 0) void'(q.pop_front());
        mem_next = $urandom;
        if (g == 1 && !cw) begin q.push_back('{1'b0, memval(ca)}); mem_next = memval(ca); end
        if (g == 2 && !ew) begin q.push_back('{1'b1, memval(ea)}); mem_next = memval(ea); end
        if (!r || g == 0) begin m_state = 0; m_cnt = 0; end
        else begin
            m_cnt   = (g != m_state) ? 1 : (m_cnt < MB ? m_cnt + 1 : MB);
            m_state = g;
        end
    endtask

    task automatic idle();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (2) cyc(0, 1, 0, 32'h1001_0000, 0, 1, 0, 32'h1001_0004, 0);
        chk("rst_gnt", 64'({og_c, og_e}), 64'd0);
        cyc(1, 1, 0, 32'h1001_0000, 0, 1, 0, 32'h1001_0004, 0);
        chk("rel_cpu_gnt", 64'(og_c), 64'd1);
        idle();
        cyc(1, 1, 0, 32'h1001_0000, 0, 1, 0, 32'h1001_0004, 0);
        chk("tie_c0", 64'(og_c), 64'd1);
        cyc(1, 0, 0, 0, 0, 1, 0, 32'h1001_0004, 0);
        chk("tie_e1", 64'(og_e), 64'd1);
        idle();
        pat = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1, 1, 0, 32'h1001_0100 + 32'(4 * i), 0, 1, 0, 32'h1001_0200 + 32'(4 * i), 0);
            pat = {pat[14:0], og_c};
        end
`ifdef DMEM_ARB_CPU_PRIO_EN
        chk("burst_pat", 64'(pat), 64'hFFFF);
`else
        chk("burst_pat", 64'(pat), 64'hF0F0);
`endif
        idle();
        cyc(1, 0, 0, 0, 0, 1, 0, 32'h1001_0010, 0);
        idle();
        chk("ext_rd", 64'({ext_rvalid, cpu_rvalid, ext_rdata}), {31'd0, 1'b1, 1'b0, 32'hCAFE_F00D});
        cyc(1, 1, 0, 32'h1001_0000, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 32'h1001_0004, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 32'h1001_0008, 32'h1234_5678, 0, 0, 0, 0);
        chk("wr_we", 64'({mem_we, mem_wdata}), {31'd0, 1'b1, 32'h1234_5678});
        cyc(1, 0, 0, 0, 0, 1, 0, 32'h1001_000C, 0);
        chk("early_sw", 64'({og_e, cpu_rvalid}), 64'd2);
        idle();
        idle();
        cyc(1, 1, 0, 32'h1001_0020, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        chk("rst_drop", 64'(cpu_rvalid), 64'd0);
        for (int i = 0; i < 300; i++)
            cyc(($urandom_range(0, 39) != 0), 1'($urandom), 1'($urandom), $urandom, $urandom,
                1'($urandom), 1'($urandom), $urandom, $urandom);
        idle();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
